// File: rtl/custom_periph_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit read/write registers to user logic,
// with byte strobes and a one-cycle write strobe per committed register.
module custom_periph_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic [2:0]                          S_AXI_AWPROT,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0]   S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic                                S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic [2:0]                          S_AXI_ARPROT,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID,
  input  logic                                S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg3_o,
  output logic [3:0]                          reg_wr_pulse_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0]     old_v,
                                               input logic [DW-1:0]     new_v,
                                               input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [3:0][DW-1:0] regs_q, regs_d;
  w_state_e           w_state_q, w_state_d;
  logic               aw_held_q, aw_held_d;
  logic               w_held_q, w_held_d;
  logic [1:0]         aw_idx_q, aw_idx_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [3:0]         pulse_q, pulse_d;
  r_state_e           r_state_q, r_state_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel: collect AW and W independently, commit once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    pulse_d   = 4'b0000;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          regs_d[aw_idx_q] = strb_merge(regs_q[aw_idx_q], wdata_q, wstrb_q);
          pulse_d          = 4'b0001 << aw_idx_q;
          bvalid_d         = 1'b1;
          w_state_d        = W_RESP;
        end else begin
          if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
          end else begin
            aw_held_d = aw_held_q;
          end
          if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end else begin
            w_held_d = w_held_q;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    // Readies are registered, so they are computed from the next-state view.
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read channel: sample the addressed register on the AR handshake and hold it.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d   = regs_q[S_AXI_ARADDR[3:2]];
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end else begin
          rvalid_d  = 1'b0;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // State and output registers for both channels.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q    <= '0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= 2'b00;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      pulse_q   <= 4'b0000;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      pulse_q   <= pulse_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = 2'b00;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = 2'b00;
  assign reg0_o         = regs_q[0];
  assign reg1_o         = regs_q[1];
  assign reg2_o         = regs_q[2];
  assign reg3_o         = regs_q[3];
  assign reg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_custom_periph_axil_regs.sv
// Directed self-checking bench for custom_periph_axil_regs.
module tb_custom_periph_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  reg_wr_pulse_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  custom_periph_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .reg_wr_pulse_o(reg_wr_pulse_o)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Full write: independent AW/W handshakes, then wait for B and report resp/pulse seen with BVALID.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [3:0] pulse);
    bit aw_done, w_done, aw_go, w_go;
    aw_done = 1'b0; w_done = 1'b0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 20 && !S_AXI_BVALID; i++) step();
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1) begin
      n_fail++; $display("FAIL write_bvalid_timeout addr=%0h: got %b expected 1", addr, S_AXI_BVALID);
    end
    resp = S_AXI_BRESP; pulse = reg_wr_pulse_o;
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_go;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20 && S_AXI_ARVALID; i++) begin
      ar_go = S_AXI_ARREADY;
      step();
      if (ar_go) S_AXI_ARVALID = 1'b0;
    end
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 20 && !S_AXI_RVALID; i++) step();
    n_cmp++;
    if (S_AXI_RVALID !== 1'b1) begin
      n_fail++; $display("FAIL read_rvalid_timeout addr=%0h: got %b expected 1", addr, S_AXI_RVALID);
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_z;
    exp_z = 32'h0;
    ARESETN = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    step(); step();
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    n_cmp++;
    if ({reg0_o | reg1_o | reg2_o | reg3_o | S_AXI_RDATA} !== exp_z) begin
      n_fail++; $display("FAIL reset_data: got %h expected %h", reg0_o | reg1_o | reg2_o | reg3_o | S_AXI_RDATA, exp_z);
    end
    n_cmp++;
    if ({reg_wr_pulse_o, S_AXI_BRESP, S_AXI_RRESP} !== 8'h00) begin
      n_fail++; $display("FAIL reset_pulse_resp: got %h expected 00", {reg_wr_pulse_o, S_AXI_BRESP, S_AXI_RRESP});
    end
    ARESETN = 1'b1;
    step();
    n_cmp++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, resp, pulse);
      n_cmp++;
      if (resp !== 2'b00 || pulse !== 4'(1 << i)) begin
        n_fail++; $display("FAIL basic_write%0d: got resp=%b pulse=%b expected resp=00 pulse=%b", i, resp, pulse, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), rd, resp);
      n_cmp++;
      if (rd !== 32'(i + 1) || resp !== 2'b00) begin
        n_fail++; $display("FAIL basic_read%0d: got %h/%b expected %h/00", i, rd, resp, 32'(i + 1));
      end
    end
    n_cmp++;
    if ({reg0_o, reg1_o, reg2_o, reg3_o} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      n_fail++; $display("FAIL basic_regs: got %h %h %h %h expected 1 2 3 4", reg0_o, reg1_o, reg2_o, reg3_o);
    end
  endtask

  task automatic test_w_before_aw();
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_WVALID = 1'b0;
    n_cmp++;
    if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL wfirst_ready: got w=%b aw=%b expected w=0 aw=1", S_AXI_WREADY, S_AXI_AWREADY);
    end
    step(); step();
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse_o !== 4'b0000 || reg2_o !== 32'd3) begin
      n_fail++; $display("FAIL wfirst_early: got bvalid=%b pulse=%b reg2=%h expected 0 0000 3", S_AXI_BVALID, reg_wr_pulse_o, reg2_o);
    end
    step();
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1 || reg_wr_pulse_o !== 4'b0100 || reg2_o !== 32'hDEADBEEF || S_AXI_BRESP !== 2'b00) begin
      n_fail++; $display("FAIL wfirst_commit: got bvalid=%b pulse=%b reg2=%h expected 1 0100 deadbeef", S_AXI_BVALID, reg_wr_pulse_o, reg2_o);
    end
    step();
    n_cmp++;
    if (reg_wr_pulse_o !== 4'b0000 || S_AXI_BVALID !== 1'b1) begin
      n_fail++; $display("FAIL wfirst_pulse_once: got pulse=%b bvalid=%b expected 0000 1", reg_wr_pulse_o, S_AXI_BVALID);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b0) begin
      n_fail++; $display("FAIL wfirst_bdone: got %b expected 0", S_AXI_BVALID);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] rd;
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, resp, pulse);
    do_write(4'h5, 32'h12345678, 4'b0101, resp, pulse);
    do_read(4'h4, rd, resp);
    n_cmp++;
    if (rd !== 32'hFF34FF78 || reg1_o !== 32'hFF34FF78) begin
      n_fail++; $display("FAIL strobe_merge: got rd=%h reg1=%h expected ff34ff78", rd, reg1_o);
    end
  endtask

  task automatic test_zero_strobe();
    logic [1:0] resp; logic [3:0] pulse;
    do_write(4'h8, 32'h00000000, 4'b0000, resp, pulse);
    n_cmp++;
    if (resp !== 2'b00 || pulse !== 4'b0100 || reg2_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL zero_strobe: got resp=%b pulse=%b reg2=%h expected 00 0100 deadbeef", resp, pulse, reg2_o);
    end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] rd;
    do_write(4'h0, 32'hA, 4'hF, resp, pulse);
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hB; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n_cmp++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA) begin
      n_fail++; $display("FAIL collide_read: got rvalid=%b rdata=%h expected 1 a", S_AXI_RVALID, S_AXI_RDATA);
    end
    step();
    n_cmp++;
    if (reg0_o !== 32'hB || S_AXI_RDATA !== 32'hA || S_AXI_RVALID !== 1'b1) begin
      n_fail++; $display("FAIL collide_hold: got reg0=%h rdata=%h rvalid=%b expected b a 1", reg0_o, S_AXI_RDATA, S_AXI_RVALID);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    do_read(4'h0, rd, resp);
    n_cmp++;
    if (rd !== 32'hB) begin
      n_fail++; $display("FAIL collide_reread: got %h expected b", rd);
    end
    // Read handshake lands on the very edge the write commits.
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hC; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0;
    n_cmp++;
    if (S_AXI_RDATA !== 32'hB || reg0_o !== 32'hC || S_AXI_RVALID !== 1'b1) begin
      n_fail++; $display("FAIL commit_edge_read: got rdata=%h reg0=%h rvalid=%b expected b c 1", S_AXI_RDATA, reg0_o, S_AXI_RVALID);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_back_to_back();
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    step();
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h99; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
        n_fail++; $display("FAIL stall_cycle%0d: got bvalid/awready/wready=%b expected 100", i,
                           {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
      end
    end
    n_cmp++;
    if (reg0_o !== 32'hC || reg3_o !== 32'h77) begin
      n_fail++; $display("FAIL stall_regs: got reg0=%h reg3=%h expected c 77", reg0_o, reg3_o);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    n_cmp++;
    if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
      n_fail++; $display("FAIL stall_release: got %b expected 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
    end
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    step();
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1 || reg0_o !== 32'h99 || reg_wr_pulse_o !== 4'b0001) begin
      n_fail++; $display("FAIL second_write: got bvalid=%b reg0=%h pulse=%b expected 1 99 0001", S_AXI_BVALID, reg0_o, reg_wr_pulse_o);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] rd;
    do_write(4'hC, 32'h55, 4'hF, resp, pulse);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h66; S_AXI_WVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    step();
    n_cmp++;
    if (S_AXI_BVALID !== 1'b1 || reg3_o !== 32'h55) begin
      n_fail++; $display("FAIL rst_pre: got bvalid=%b reg3=%h expected 1 55", S_AXI_BVALID, reg3_o);
    end
    ARESETN = 1'b0;
    #2;
    n_cmp++;
    if (S_AXI_BVALID !== 1'b0 || reg3_o !== 32'h0 || reg1_o !== 32'h0 || S_AXI_AWREADY !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got bvalid=%b reg3=%h reg1=%h awready=%b expected 0 0 0 0",
                         S_AXI_BVALID, reg3_o, reg1_o, S_AXI_AWREADY);
    end
    step(); step();
    ARESETN = 1'b1;
    step();
    n_cmp++;
    if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse_o !== 4'b0000) begin
      n_fail++; $display("FAIL rst_after: got bvalid=%b pulse=%b expected 0 0000", S_AXI_BVALID, reg_wr_pulse_o);
    end
    do_write(4'hC, 32'h1234, 4'hF, resp, pulse);
    do_read(4'hC, rd, resp);
    n_cmp++;
    if (rd !== 32'h1234 || resp !== 2'b00 || reg1_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_recover: got rd=%h resp=%b reg1=%h expected 1234 00 0", rd, resp, reg1_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strobe();
    test_zero_strobe();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
